// File: rtl/or9_request_arbiter_if.sv
// Request/grant bundle between up to nine bus masters and the shared-resource arbiter.
// The master side drives the requests; the slave side is the arbiter itself.
interface or9_request_arbiter_if;
    logic [8:0] request;
    logic       enable;
    logic       grant_release;
    logic       any_request;
    logic [8:0] grant;
    logic       grant_valid;
    logic [3:0] grant_index;
    logic       timeout;

    modport master (
        output request,
        output enable,
        output grant_release,
        input  any_request,
        input  grant,
        input  grant_valid,
        input  grant_index,
        input  timeout
    );

    modport slave (
        input  request,
        input  enable,
        input  grant_release,
        output any_request,
        output grant,
        output grant_valid,
        output grant_index,
        output timeout
    );
endinterface

// File: rtl/or9_request_arbiter.sv
// Nine-input round-robin arbiter with per-input bubbles and a bounded grant hold time.
// Define ARB_FIXED_PRIORITY_EN to select the lowest-index request instead of round-robin.
module or9_request_arbiter #(
    parameter logic [8:0] BubblesMask = 9'h000,
    parameter int         MaxHold     = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    or9_request_arbiter_if.slave        bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    localparam logic [7:0] HoldLast = 8'(MaxHold - 1);

    state_t     state_reg;
    logic [8:0] grant_reg;
    logic       grant_valid_reg;
    logic [3:0] grant_index_reg;
    logic       timeout_reg;
    logic [3:0] last_reg;
    logic [7:0] hold_cnt_reg;

    logic [8:0] eff;
    logic [3:0] sel_next;
    logic [8:0] sel_onehot;

    genvar gi;

    // Bubble stage: an inverted input makes that requester active-low.
    generate
        for (gi = 0; gi < 9; gi++) begin : g_bubble
            assign eff[gi] = bus.request[gi] ^ BubblesMask[gi];
        end
    endgenerate

    assign bus.any_request = |eff;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        sel_next = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (eff[k]) begin
                sel_next = 4'(k);
            end
        end
    end
`else
    logic [4:0] cand_sum [9];
    logic [3:0] cand_idx [9];
    logic [8:0] cand_hit;

    // Candidate k is the (k+1)-th index after the last holder, modulo 9.
    generate
        for (gi = 0; gi < 9; gi++) begin : g_rotate
            assign cand_sum[gi] = {1'b0, last_reg} + 5'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= 5'd9) ? 4'(cand_sum[gi] - 5'd9)
                                                         : cand_sum[gi][3:0];
            assign cand_hit[gi] = eff[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        sel_next = last_reg;
        for (int k = 8; k >= 0; k--) begin
            if (cand_hit[k]) begin
                sel_next = cand_idx[k];
            end
        end
    end
`endif

    generate
        for (gi = 0; gi < 9; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_next == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_reg       <= 9'h000;
            grant_valid_reg <= 1'b0;
            grant_index_reg <= 4'd0;
            timeout_reg     <= 1'b0;
            last_reg        <= 4'd8;
            hold_cnt_reg    <= 8'd0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.enable && bus.any_request) begin
                        state_reg       <= GRANTED;
                        grant_reg       <= sel_onehot;
                        grant_valid_reg <= 1'b1;
                        grant_index_reg <= sel_next;
                        last_reg        <= sel_next;
                        hold_cnt_reg    <= 8'd0;
                    end
                end
                GRANTED: begin
                    // Release beats timeout, so a holder finishing on its last cycle never sees Timeout.
                    if (bus.grant_release || !eff[grant_index_reg]) begin
                        state_reg       <= IDLE;
                        grant_reg       <= 9'h000;
                        grant_valid_reg <= 1'b0;
                    end else if (hold_cnt_reg == HoldLast) begin
                        state_reg       <= IDLE;
                        grant_reg       <= 9'h000;
                        grant_valid_reg <= 1'b0;
                        timeout_reg     <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_reg       <= 9'h000;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.grant_valid = grant_valid_reg;
    assign bus.grant_index = grant_index_reg;
    assign bus.timeout     = timeout_reg;

endmodule

// File: tb/tb_or9_request_arbiter.sv
// Bench for or9_request_arbiter: vector table, hand corner sequences, then random traffic vs a model.
// Stimulus is expressed as effective requests; the raw lines are derived through MASK.
module tb_or9_request_arbiter;

    localparam logic [8:0] MASK = 9'h100;
    localparam int         MAXH = 4;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    or9_request_arbiter_if arb_if ();

    or9_request_arbiter #(
        .BubblesMask (MASK),
        .MaxHold     (MAXH)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] eff;
        logic       en;
        logic       rel;
        logic       rst;
        logic       exp_any;
        logic [8:0] exp_grant;
        logic       exp_gv;
        logic [3:0] exp_gi;
        logic       exp_to;
    } vec_t;

    vec_t vecs [15];

    // Behavioural reference: holder is -1 when idle, age counts visible grant cycles.
    int m_holder;
    int m_last;
    int m_gi;
    int m_age;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] eff, input logic en, input logic rel, input logic rst);
        arb_if.request       = eff ^ MASK;
        arb_if.enable        = en;
        arb_if.grant_release = rel;
        reset                = rst;
    endtask

    task automatic step(input string name, input logic [8:0] eff, input logic en, input logic rel,
                        input logic rst, input logic exp_any, input logic [8:0] exp_grant,
                        input logic exp_gv, input logic [3:0] exp_gi, input logic exp_to);
        drive(eff, en, rel, rst);
        #2;
        check({name, ".any"}, 32'(arb_if.any_request), 32'(exp_any));
        @(posedge clk);
        #1;
        check({name, ".grant"}, 32'(arb_if.grant), 32'(exp_grant));
        check({name, ".valid"}, 32'(arb_if.grant_valid), 32'(exp_gv));
        check({name, ".index"}, 32'(arb_if.grant_index), 32'(exp_gi));
        check({name, ".timeout"}, 32'(arb_if.timeout), 32'(exp_to));
        $display("txn %s eff=%03h en=%0b rel=%0b rst=%0b -> grant=%03h valid=%0b idx=%0d to=%0b",
                 name, eff, en, rel, rst, arb_if.grant, arb_if.grant_valid,
                 arb_if.grant_index, arb_if.timeout);
    endtask

    task automatic model_step(input logic [8:0] eff, input logic en, input logic rel, input logic rst);
        int pick;
        pick = -1;
        if (rst) begin
            m_holder = -1;
            m_gi     = 0;
            m_last   = 8;
            m_to     = 1'b0;
            m_age    = 0;
        end else begin
            m_to = 1'b0;
            if (m_holder < 0) begin
                if (en && eff != 9'h000) begin
                    if (FIXED) begin
                        for (int c = 0; c < 9; c++)
                            if (pick < 0 && eff[c]) pick = c;
                    end else begin
                        for (int k = 1; k <= 9; k++)
                            if (pick < 0 && eff[(m_last + k) % 9]) pick = (m_last + k) % 9;
                    end
                    m_holder = pick;
                    m_gi     = pick;
                    m_last   = pick;
                    m_age    = 1;
                end
            end else if (rel || !eff[m_holder]) begin
                m_holder = -1;
            end else if (m_age == MAXH) begin
                m_holder = -1;
                m_to     = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    initial begin
        logic [8:0] r_eff;
        logic       r_en;
        logic       r_rel;
        logic       r_rst;
        logic [8:0] exp_g;
        logic [3:0] rr_i;

        n_tests = 0;
        n_fail  = 0;
        r_eff   = 9'h000;

        // eff, en, rel, rst, any, grant, valid, index, timeout
        vecs[0]  = '{9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{9'h011, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001, 1'b1, 4'd0, 1'b0};
        vecs[3]  = '{9'h011, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[4]  = '{9'h011, 1'b1, 1'b0, 1'b0, 1'b1, FIXED ? 9'h001 : 9'h010, 1'b1,
                     FIXED ? 4'd0 : 4'd4, 1'b0};
        vecs[5]  = '{9'h011, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, FIXED ? 4'd0 : 4'd4, 1'b0};
        vecs[6]  = '{9'h011, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001, 1'b1, 4'd0, 1'b0};
        vecs[7]  = '{9'h011, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[8]  = '{9'h001, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{9'h001, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001, 1'b1, 4'd0, 1'b0};
        vecs[10] = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[11] = '{9'h100, 1'b1, 1'b0, 1'b0, 1'b1, 9'h100, 1'b1, 4'd8, 1'b0};
        vecs[12] = '{9'h100, 1'b0, 1'b0, 1'b0, 1'b1, 9'h100, 1'b1, 4'd8, 1'b0};
        vecs[13] = '{9'h100, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 1'b0};
        vecs[14] = '{9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 4'd8, 1'b0};

        drive(9'h000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vecs[i].eff, vecs[i].en, vecs[i].rel, vecs[i].rst,
                 vecs[i].exp_any, vecs[i].exp_grant, vecs[i].exp_gv, vecs[i].exp_gi, vecs[i].exp_to);
        end

        // Idle with no requests stays quiet for ten cycles.
        step("quiet_rst", 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("quiet", 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0);

        // Timeout after MAXH granted cycles, one idle cycle, then re-grant of the same requester.
        step("to_grant", 9'h008, 1'b1, 1'b0, 1'b0, 1'b1, 9'h008, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < MAXH - 1; i++)
            step("to_hold", 9'h008, 1'b1, 1'b0, 1'b0, 1'b1, 9'h008, 1'b1, 4'd3, 1'b0);
        step("to_drop", 9'h008, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd3, 1'b1);
        step("to_regrant", 9'h008, 1'b1, 1'b0, 1'b0, 1'b1, 9'h008, 1'b1, 4'd3, 1'b0);

        // Release on the final hold cycle suppresses the timeout pulse.
        for (int i = 0; i < MAXH - 1; i++)
            step("rt_hold", 9'h008, 1'b1, 1'b0, 1'b0, 1'b1, 9'h008, 1'b1, 4'd3, 1'b0);
        step("rt_release", 9'h008, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd3, 1'b0);

        // Reset mid-grant drops the grant and restores the search start to index 0.
        step("mr_grant", 9'h004, 1'b1, 1'b0, 1'b0, 1'b1, 9'h004, 1'b1, 4'd2, 1'b0);
        step("mr_reset", 9'h004, 1'b1, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 4'd0, 1'b0);
        step("mr_after", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001, 1'b1, 4'd0, 1'b0);
        step("mr_rel", 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 1'b0);

        // All requesting with a release after each grant: rotation (or index 0 when fixed).
        for (int n = 1; n <= 10; n++) begin
            rr_i  = FIXED ? 4'd0 : 4'(n % 9);
            exp_g = 9'h001 << rr_i;
            step("all_grant", 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, exp_g, 1'b1, rr_i, 1'b0);
            step("all_rel", 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, rr_i, 1'b0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r_eff = 9'h000;
                1: r_eff = 9'h001 << $urandom_range(0, 8);
                2: r_eff = 9'($urandom);
                default: r_eff = r_eff;
            endcase
            r_en  = ($urandom_range(0, 9) != 0);
            r_rel = ($urandom_range(0, 5) == 0);
            r_rst = (i == 0) || ($urandom_range(0, 99) == 0);
            drive(r_eff, r_en, r_rel, r_rst);
            #2;
            check("rnd.any", 32'(arb_if.any_request), 32'(r_eff != 9'h000));
            @(posedge clk);
            model_step(r_eff, r_en, r_rel, r_rst);
            #1;
            exp_g = (m_holder >= 0) ? (9'h001 << m_holder) : 9'h000;
            check("rnd.grant", 32'(arb_if.grant), 32'(exp_g));
            check("rnd.valid", 32'(arb_if.grant_valid), 32'(m_holder >= 0));
            check("rnd.index", 32'(arb_if.grant_index), 32'(m_gi));
            check("rnd.timeout", 32'(arb_if.timeout), 32'(m_to));
            $display("txn rnd%0d eff=%03h en=%0b rel=%0b rst=%0b -> grant=%03h idx=%0d to=%0b",
                     i, r_eff, r_en, r_rel, r_rst, arb_if.grant, arb_if.grant_index, arb_if.timeout);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
